sram_req_arbiter: RTL and testbench

Shares one SRAM-like master port between the CPU's instruction-fetch and data-access SRAM-like requesters, ahead of the AXI bridge. It picks one request per cycle and holds that choice stable until the master port accepts it. It records the source of every accepted request in an in-order tracking FIFO, and steers each returning `data_ok`/`rdata` back to the requester that issued it. Data requests have priority, with a bounded-run fairness rule so instruction fetch cannot starve.

---
 rtl/sram_req_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like master port between the instruction-fetch and data requesters.
// Data has priority with a bounded run; an in-order FIFO routes each response back to its issuer.
module sram_req_arbiter #(
    parameter int OT_DEPTH = 4,
    parameter int DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        err_stray
);

    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(DATA_RUN + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(OT_DEPTH);
    localparam logic [RW-1:0] RUN_MAX = RW'(DATA_RUN);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    state_e         state_q, state_d;
    logic           src_q, src_d;
    logic [RW-1:0]  run_cnt_q, run_cnt_d;
    logic [OT_DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_stray_q, err_stray_d;

    logic can_issue;
    logic sel_data;
    logic accept;
    logic fifo_empty;
    logic head;
    logic pop;
    logic stray;

    // Source selection; outputs stay quiet while reset is asserted so nothing is accepted then.
    always_comb begin
        can_issue = (count_q < DEPTH_C);
        sel_data  = 1'b0;
        m_req     = 1'b0;
        if (!reset) begin
            if (state_q == ST_HOLD) begin
                sel_data = src_q;
                m_req    = 1'b1;
            end else if (can_issue) begin
                sel_data = data_req && !(inst_req && (run_cnt_q == RUN_MAX));
                m_req    = sel_data || inst_req;
            end
        end
    end

    always_comb begin
        m_wr    = 1'b0;
        m_size  = '0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (m_req) begin
            if (sel_data) begin
                m_wr    = data_wr;
                m_size  = data_size;
                m_wstrb = data_wstrb;
                m_addr  = data_addr;
                m_wdata = data_wdata;
            end else begin
                m_wr    = inst_wr;
                m_size  = inst_size;
                m_wstrb = inst_wstrb;
                m_addr  = inst_addr;
                m_wdata = inst_wdata;
            end
        end
    end

    assign accept       = m_req & m_addr_ok;
    assign inst_addr_ok = accept & ~sel_data;
    assign data_addr_ok = accept & sel_data;

    assign fifo_empty   = (count_q == '0);
    assign head         = fifo_q[rd_ptr_q];
    assign pop          = m_data_ok & ~fifo_empty & ~reset;
    assign stray        = m_data_ok & fifo_empty & ~reset;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign err_stray    = err_stray_q;

    // Next-state for the arbiter FSM, fairness counter and tracking FIFO.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        run_cnt_d   = run_cnt_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_stray_d = err_stray_q | stray;

        case (state_q)
            ST_IDLE: begin
                if (m_req && !m_addr_ok) begin
                    state_d = ST_HOLD;
                    src_d   = sel_data;
                end
            end
            ST_HOLD: begin
                if (m_addr_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!inst_req || (accept && !sel_data)) begin
            run_cnt_d = '0;
        end else if (accept && (run_cnt_q != RUN_MAX)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        if (accept) begin
            fifo_d[wr_ptr_q] = sel_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= 1'b0;
            run_cnt_q   <= '0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            run_cnt_q   <= run_cnt_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_stray_q <= err_stray_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_sram_req_arbiter;

    localparam int OT_DEPTH = 4;
    localparam int DATA_RUN = 4;
    localparam logic [31:0] IA     = 32'h1C00_0000;
    localparam logic [31:0] DA     = 32'h0000_1000;
    localparam logic [31:0] DWDATA = 32'h5555_AAAA;
    localparam logic [1:0]  ISIZE  = 2'b10;
    localparam logic [1:0]  DSIZE  = 2'b01;
    localparam logic [3:0]  ISTRB  = 4'hF;
    localparam logic [3:0]  DSTRB  = 4'h3;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        err_stray;

    typedef struct {
        logic        inst_req;
        logic        data_req;
        logic        m_addr_ok;
        logic        m_data_ok;
        logic [31:0] m_rdata;
    } stim_t;

    typedef struct {
        logic        m_req;
        logic        m_wr;
        logic [1:0]  m_size;
        logic [3:0]  m_wstrb;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        inst_addr_ok;
        logic        data_addr_ok;
        logic        inst_data_ok;
        logic        data_data_ok;
        logic        err_stray;
    } expect_t;

    typedef struct {
        stim_t   s;
        expect_t e;
    } vec_t;

    int vectors;
    int miscompares;
    bit cur_bad;

    sram_req_arbiter #(
        .OT_DEPTH(OT_DEPTH),
        .DATA_RUN(DATA_RUN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_wstrb      (m_wstrb),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .err_stray    (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic expect_t mkexp(bit req, bit isdata, bit iaok, bit daok,
                                      bit idok, bit ddok, bit err);
        expect_t e;
        e.m_req        = req;
        e.m_wr         = 1'b0;
        e.m_size       = '0;
        e.m_wstrb      = '0;
        e.m_addr       = '0;
        e.m_wdata      = '0;
        if (req) begin
            e.m_wr    = isdata;
            e.m_size  = isdata ? DSIZE : ISIZE;
            e.m_wstrb = isdata ? DSTRB : ISTRB;
            e.m_addr  = isdata ? DA : IA;
            e.m_wdata = isdata ? DWDATA : 32'h0;
        end
        e.inst_addr_ok = iaok;
        e.data_addr_ok = daok;
        e.inst_data_ok = idok;
        e.data_data_ok = ddok;
        e.err_stray    = err;
        return e;
    endfunction

    function automatic vec_t mk(bit ir, bit dr, bit aok, bit dok, logic [31:0] rd,
                                bit ereq, bit edata, bit iaok, bit daok,
                                bit idok, bit ddok, bit err);
        vec_t v;
        v.s.inst_req  = ir;
        v.s.data_req  = dr;
        v.s.m_addr_ok = aok;
        v.s.m_data_ok = dok;
        v.s.m_rdata   = rd;
        v.e = mkexp(ereq, edata, iaok, daok, idok, ddok, err);
        return v;
    endfunction

    task automatic applyStimulus(input stim_t s);
        inst_req   = s.inst_req;
        inst_wr    = 1'b0;
        inst_size  = ISIZE;
        inst_wstrb = ISTRB;
        inst_addr  = IA;
        inst_wdata = 32'h0;
        data_req   = s.data_req;
        data_wr    = 1'b1;
        data_size  = DSIZE;
        data_wstrb = DSTRB;
        data_addr  = DA;
        data_wdata = DWDATA;
        m_addr_ok  = s.m_addr_ok;
        m_data_ok  = s.m_data_ok;
        m_rdata    = s.m_rdata;
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, field, act, exp);
            cur_bad = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input expect_t e);
        vectors++;
        cur_bad = 1'b0;
        cmp(tag, "m_req",        32'(m_req),        32'(e.m_req));
        cmp(tag, "m_wr",         32'(m_wr),         32'(e.m_wr));
        cmp(tag, "m_size",       32'(m_size),       32'(e.m_size));
        cmp(tag, "m_wstrb",      32'(m_wstrb),      32'(e.m_wstrb));
        cmp(tag, "m_addr",       m_addr,            e.m_addr);
        cmp(tag, "m_wdata",      m_wdata,           e.m_wdata);
        cmp(tag, "inst_addr_ok", 32'(inst_addr_ok), 32'(e.inst_addr_ok));
        cmp(tag, "data_addr_ok", 32'(data_addr_ok), 32'(e.data_addr_ok));
        cmp(tag, "inst_data_ok", 32'(inst_data_ok), 32'(e.inst_data_ok));
        cmp(tag, "data_data_ok", 32'(data_data_ok), 32'(e.data_data_ok));
        cmp(tag, "err_stray",    32'(err_stray),    32'(e.err_stray));
        cmp(tag, "inst_rdata",   inst_rdata,        m_rdata);
        cmp(tag, "data_rdata",   data_rdata,        m_rdata);
        if (cur_bad) miscompares++;
    endtask

    task automatic step(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        applyStimulus(v.s);
        @(negedge clk);
        checkOutput(tag, v.e);
    endtask

    task automatic doReset(input string tag);
        vec_t z;
        z = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(z.s);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput(tag, z.e);
        reset = 1'b0;
    endtask

    // Reference model state: queue of issuing sources, a held source, a run length.
    bit q[$];
    int held;
    int run;
    bit stray_m;

    initial begin
        vec_t tbl[$];
        vec_t z;
        bit   ipend, dpend;
        bit   req, sel, acc;
        expect_t e;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        z = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(z.s);
        doReset("reset");

        // ir dr aok dok rdata | req data iaok daok idok ddok err
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'hAAAA_0001, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'hBBBB_0002, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0001, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0002, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // Both requesters saturated: expect D,D,D,D,I repeating, each response drained next cycle.
        for (int k = 0; k < 10; k++) begin
            bit is_d, prev_d;
            is_d   = (k % 5) != 4;
            prev_d = ((k + 4) % 5) != 4;
            step($sformatf("fair%0d", k),
                 mk(1, 1, 1, k > 0, 32'hC000_0000 + k, 1, is_d, !is_d, is_d,
                    (k > 0) && !prev_d, (k > 0) && prev_d, 0));
        end
        step("fair_drain", mk(0, 0, 0, 1, 32'hC000_00FF, 0, 0, 0, 0, 1, 0, 0));

        for (int k = 0; k < 4; k++) begin
            step($sformatf("fill%0d", k), mk(0, 1, 1, 0, 32'h0, 1, 1, 0, 1, 0, 0, 0));
        end
        step("full_block", mk(0, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0));
        step("full_pop",   mk(0, 1, 1, 1, 32'hD00D_0000, 0, 0, 0, 0, 0, 1, 0));
        step("full_retry", mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            step($sformatf("full_drain%0d", k),
                 mk(0, 0, 0, 1, 32'hD00D_0001 + k, 0, 0, 0, 0, 0, 1, 0));
        end

        step("stray0", mk(0, 0, 0, 1, 32'hEEEE_0000, 0, 0, 0, 0, 0, 0, 0));
        step("stray1", mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 1));
        step("stray2", mk(0, 0, 0, 1, 32'hEEEE_0001, 0, 0, 0, 0, 0, 0, 1));
        step("stray3", mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 1));
        step("stray4", mk(0, 0, 0, 1, 32'hEEEE_0002, 0, 0, 0, 0, 1, 0, 1));
        doReset("reset_clears_stray");

        // Randomized traffic against the reference model.
        q.delete();
        held    = -1;
        run     = 0;
        stray_m = 1'b0;
        ipend   = 1'b0;
        dpend   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!ipend && ($urandom_range(0, 1) == 1)) begin
                ipend      = 1'b1;
                inst_addr  = $urandom;
                inst_wr    = 1'($urandom);
                inst_size  = 2'($urandom);
                inst_wstrb = 4'($urandom);
                inst_wdata = $urandom;
            end
            if (!dpend && ($urandom_range(0, 7) != 0)) begin
                dpend      = 1'b1;
                data_addr  = $urandom;
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom);
                data_wstrb = 4'($urandom);
                data_wdata = $urandom;
            end
            inst_req  = ipend;
            data_req  = dpend;
            m_addr_ok = ($urandom_range(0, 2) != 0);
            m_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            m_rdata   = $urandom;

            req = 1'b0;
            sel = 1'b0;
            if (held >= 0) begin
                req = 1'b1;
                sel = (held == 1);
            end else if (q.size() < OT_DEPTH) begin
                if (data_req && !(inst_req && run == DATA_RUN)) begin
                    req = 1'b1;
                    sel = 1'b1;
                end else if (inst_req) begin
                    req = 1'b1;
                end
            end
            acc = req && m_addr_ok;

            e = mkexp(0, 0, !sel && acc, sel && acc,
                      m_data_ok && q.size() > 0 && q[0] == 1'b0,
                      m_data_ok && q.size() > 0 && q[0] == 1'b1, stray_m);
            e.m_req = req;
            if (req) begin
                e.m_wr    = sel ? data_wr    : inst_wr;
                e.m_size  = sel ? data_size  : inst_size;
                e.m_wstrb = sel ? data_wstrb : inst_wstrb;
                e.m_addr  = sel ? data_addr  : inst_addr;
                e.m_wdata = sel ? data_wdata : inst_wdata;
            end

            @(negedge clk);
            checkOutput($sformatf("rand%0d", c), e);

            if (m_data_ok) begin
                if (q.size() > 0) void'(q.pop_front());
                else stray_m = 1'b1;
            end
            if (acc) begin
                q.push_back(sel);
                held = -1;
                if (sel) dpend = 1'b0;
                else ipend = 1'b0;
            end else if (req && held < 0) begin
                held = sel ? 1 : 0;
            end
            if (!inst_req || (acc && !sel)) run = 0;
            else if (acc && run < DATA_RUN) run++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
